neumaier_tree_scheduler: RTL and testbench

Sequences a multi-chunk dot-product reduction through the pipelined Neumaier adder tree. It accepts a job of N chunks, where each chunk is ELEMS_COUNT elements wide. It gates chunks into the tree with a valid/ready handshake and tracks in-flight chunks with a valid shift register aligned to the tree's fixed pipeline latency. It accumulates the tree's per-chunk sums into one wide result and reports done. It sits between the operand fetch stream and the adder tree instance.

---
 rtl/neumaier_tree_scheduler.sv | 105 ++++++++++
 tb/tb_neumaier_tree_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/neumaier_tree_scheduler.sv
// Job sequencer for the pipelined Neumaier adder tree: it gates chunks into the tree,
// tracks them through the tree latency and sums the per-chunk results into one wide value.
module neumaier_tree_scheduler #(
   parameter int SUM_WIDTH  = 13,
   parameter int TREE_LAT   = 8,
   parameter int MAX_CHUNKS = 256,
   parameter int CNT_W      = 9,
   parameter int ACC_W      = SUM_WIDTH + 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic [CNT_W-1:0]            num_chunks_i,
   output logic                        busy_o,
   input  logic                        chunk_valid_i,
   output logic                        chunk_ready_o,
   output logic                        tree_in_sel_o,
   input  logic signed [SUM_WIDTH-1:0] tree_sum_i,
   output logic signed [ACC_W-1:0]     acc_o,
   output logic                        done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CHUNKS);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          n_q, issued_q, retired_q;
   logic [CNT_W-1:0]          n_sat, issued_inc;
   logic [TREE_LAT-1:0]       vpipe_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   sum_ext;
   logic                      ready_w, handshake, retire, start_acc;

   assign n_sat      = (num_chunks_i > MAX_C) ? MAX_C : num_chunks_i;
   assign issued_inc = issued_q + CNT_W'(1);
   assign ready_w    = (state_q == RUN) && (issued_q < n_q);
   assign handshake  = ready_w & chunk_valid_i;
   assign retire     = vpipe_q[TREE_LAT-1];
   assign sum_ext    = {{(ACC_W-SUM_WIDTH){tree_sum_i[SUM_WIDTH-1]}}, tree_sum_i};

   assign chunk_ready_o = ready_w;
   assign tree_in_sel_o = handshake;
   assign acc_o         = acc_q;

   // Next-state and status outputs; an empty job passes through DRAIN, which
   // completes at once because nothing was issued.
   always_comb begin
      state_d   = state_q;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      start_acc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               state_d   = (n_sat == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            busy_o = 1'b1;
            if (handshake && (issued_inc == n_q)) state_d = DRAIN;
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (retired_q == n_q) state_d = DONE;
         end
         DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The valid pipe mirrors the tree latency, so its last bit marks the cycle
   // in which tree_sum_i belongs to a real chunk rather than a zero bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         n_q       <= '0;
         issued_q  <= '0;
         retired_q <= '0;
         vpipe_q   <= '0;
         acc_q     <= '0;
      end else begin
         state_q <= state_d;
         vpipe_q <= {vpipe_q[TREE_LAT-2:0], handshake};
         if (start_acc) begin
            n_q       <= n_sat;
            issued_q  <= '0;
            retired_q <= '0;
            acc_q     <= '0;
         end else begin
            if (handshake) issued_q <= issued_inc;
            if (retire) begin
               acc_q     <= acc_q + sum_ext;
               retired_q <= retired_q + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_neumaier_tree_scheduler.sv
// Directed bench for neumaier_tree_scheduler with a delay-line model of the adder tree
// and a scoreboard of expected job results.
module tb_neumaier_tree_scheduler;

   localparam int SUM_WIDTH = 13;
   localparam int TREE_LAT  = 8;
   localparam int CNT_W     = 9;
   localparam int ACC_W     = SUM_WIDTH + 8;
   localparam logic signed [SUM_WIDTH-1:0] JUNK = 13'sd1234;

   logic                        clk_i = 1'b0;
   logic                        rst_i;
   logic                        start_i;
   logic [CNT_W-1:0]            num_chunks_i;
   logic                        busy_o;
   logic                        chunk_valid_i;
   logic                        chunk_ready_o;
   logic                        tree_in_sel_o;
   logic signed [SUM_WIDTH-1:0] tree_sum_i;
   logic signed [ACC_W-1:0]     acc_o;
   logic                        done_o;

   int      total = 0;
   int      bad   = 0;
   int      cyc   = 0;
   int      start_cyc;
   longint  prev_acc = 0;
   int      stage_vals[$];
   int      chunk_vals[$];
   longint  exp_q[$];

   logic signed [SUM_WIDTH-1:0] tq [TREE_LAT];
   logic signed [SUM_WIDTH-1:0] val_s;

   neumaier_tree_scheduler dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .num_chunks_i  (num_chunks_i),
      .busy_o        (busy_o),
      .chunk_valid_i (chunk_valid_i),
      .chunk_ready_o (chunk_ready_o),
      .tree_in_sel_o (tree_in_sel_o),
      .tree_sum_i    (tree_sum_i),
      .acc_o         (acc_o),
      .done_o        (done_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Tree model: a chunk gated in during a cycle shows up on tree_sum_i TREE_LAT
   // cycles later; bubble slots carry a nonzero junk value that must never be summed.
   always @(negedge clk_i) begin
      if (tree_in_sel_o === 1'b1)
         val_s <= (chunk_vals.size() > 0) ? SUM_WIDTH'(chunk_vals.pop_front()) : '0;
      else
         val_s <= JUNK;
   end

   always @(posedge clk_i) begin
      tq[0] <= val_s;
      for (int i = 1; i < TREE_LAT; i++) tq[i] <= tq[i-1];
   end

   assign tree_sum_i = tq[TREE_LAT-1];

   task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 of the start cycle; moves staged chunk sums into the tree model
   // and pushes the expected accumulation (saturated chunk count) onto the scoreboard.
   task automatic applyStimulus(input int n_req);
      int     n_eff;
      longint s;
      n_eff = (n_req > 256) ? 256 : n_req;
      s = 0;
      for (int i = 0; i < stage_vals.size(); i++) begin
         if (i < n_eff) s += stage_vals[i];
         chunk_vals.push_back(stage_vals[i]);
      end
      stage_vals.delete();
      exp_q.push_back(s);
      start_i       = 1'b1;
      num_chunks_i  = CNT_W'(n_req);
      chunk_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("idle_before_start", busy_o, 0);
      checkOutput("acc_held", acc_o, prev_acc);
      start_cyc = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   // Runs from posedge+1 of the cycle after start until done_o; ends at posedge+1 of done+1.
   task automatic runJob(input string tag, input logic [31:0] pat, input int plen,
                         input logic hold_start, input int exp_hs, input int exp_lat,
                         output int rdy);
      int     hs;
      int     lat;
      longint e;
      hs  = 0;
      rdy = 0;
      lat = -1;
      for (int idx = 0; idx < 400; idx++) begin
         chunk_valid_i = pat[idx % plen];
         if (hold_start) begin
            start_i      = 1'b1;
            num_chunks_i = 9'd7;
         end
         @(negedge clk_i);
         if (tree_in_sel_o) hs++;
         if (chunk_ready_o) rdy++;
         if (!chunk_valid_i) checkOutput({tag, "_sel_bubble"}, tree_in_sel_o, 0);
         checkOutput({tag, "_busy"}, busy_o, 1);
         if (done_o) begin
            lat = cyc - start_cyc;
            break;
         end
         @(posedge clk_i); #1;
      end
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_handshakes"}, hs, exp_hs);
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_scoreboard_empty"}, exp_q.size(), 1);
         e = 0;
      end else begin
         e = exp_q.pop_front();
      end
      checkOutput({tag, "_acc"}, acc_o, e);
      prev_acc = e;
      @(posedge clk_i); #1;
      start_i       = 1'b0;
      chunk_valid_i = 1'b0;
   endtask

   initial begin
      int rdy;
      int dones;
      rst_i         = 1'b1;
      start_i       = 1'b0;
      num_chunks_i  = '0;
      chunk_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_ready", chunk_ready_o, 0);
      checkOutput("rst_sel", tree_in_sel_o, 0);
      checkOutput("rst_acc", acc_o, 0);
      checkOutput("rst_done", done_o, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      $display("[TB] job A: N=4 back-to-back");
      stage_vals = '{10, -3, 7, 100};
      applyStimulus(4);
      runJob("A", 32'h1, 1, 1'b0, 4, 14, rdy);

      $display("[TB] job B: N=0");
      applyStimulus(0);
      runJob("B", 32'h1, 1, 1'b0, 0, 2, rdy);
      checkOutput("B_ready_never", rdy, 0);

      $display("[TB] job C: N=3 with bubbles");
      stage_vals = '{5, -20, 1000};
      applyStimulus(3);
      runJob("C", 32'b101001, 6, 1'b0, 3, 16, rdy);

      $display("[TB] job D: ignored starts, then immediate restart");
      stage_vals = '{1, 2, 3};
      applyStimulus(3);
      runJob("D1", 32'h1, 1, 1'b1, 3, 13, rdy);
      stage_vals = '{-5, -6};
      applyStimulus(2);
      runJob("D2", 32'h1, 1, 1'b0, 2, 12, rdy);

      $display("[TB] job E: reset during drain");
      stage_vals = '{9, 9, 9, 9};
      applyStimulus(4);
      chunk_valid_i = 1'b1;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         if (done_o) dones++;
         @(posedge clk_i); #1;
      end
      chunk_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      checkOutput("E_rst_busy", busy_o, 0);
      checkOutput("E_rst_ready", chunk_ready_o, 0);
      checkOutput("E_rst_sel", tree_in_sel_o, 0);
      checkOutput("E_rst_acc", acc_o, 0);
      checkOutput("E_rst_done", done_o, 0);
      void'(exp_q.pop_back());
      chunk_vals.delete();
      prev_acc = 0;
      @(negedge clk_i);
      rst_i = 1'b0;
      chunk_valid_i = 1'b1;
      rdy = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_i);
         if (done_o) dones++;
         if (busy_o || chunk_ready_o) rdy++;
      end
      checkOutput("E_no_done", dones, 0);
      checkOutput("E_stays_idle", rdy, 0);
      @(posedge clk_i); #1;
      chunk_valid_i = 1'b0;

      $display("[TB] job F: N=1 after abort");
      stage_vals = '{42};
      applyStimulus(1);
      runJob("F", 32'h1, 1, 1'b0, 1, 11, rdy);

      $display("[TB] job G: N=256 at most-negative sum");
      for (int i = 0; i < 256; i++) stage_vals.push_back(-4096);
      applyStimulus(256);
      runJob("G", 32'h1, 1, 1'b0, 256, 266, rdy);

      $display("[TB] job H: N=300 saturates");
      for (int i = 0; i < 300; i++) stage_vals.push_back(1);
      applyStimulus(300);
      runJob("H", 32'h1, 1, 1'b0, 256, 266, rdy);
      chunk_vals.delete();

      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
